// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Handles multi-cycle fetch, decode stall via skid buffer, and redirects.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic        Jump,
    input  logic [25:0] ID_Target,
    output logic        IM_Req,
    output logic [31:0] IM_Addr,
    input  logic        IM_Rdy,
    input  logic [31:0] IM_Data,
    output logic [31:0] ID_Inst,
    output logic [31:0] ID_PC4,
    output logic        ID_Valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        KILL  = 2'd1,
        BUF   = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_pc_q;
    logic [31:0] buf_inst_q;
    logic [31:0] buf_pc4_q;
    logic [31:0] id_inst_q;
    logic [31:0] id_pc4_q;
    logic        id_valid_q;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // Redirect only acts on a real instruction that decode is accepting.
    always_comb begin
        redirect = id_valid_q & ~Stall & (Jump | Branch_Taken);
        target   = Branch_Target;
        if (Jump) begin
            target = {id_pc4_q[31:28], ID_Target, 2'b00};
        end
        pc_plus4 = pc_q + 32'd4;
    end

    // Fetch control, PC, skid buffer and IF/ID register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            pend_pc_q  <= '0;
            buf_inst_q <= '0;
            buf_pc4_q  <= '0;
            id_inst_q  <= NOP_INST;
            id_pc4_q   <= '0;
            id_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (redirect && IM_Rdy) begin
                        pc_q       <= target;
                        id_inst_q  <= NOP_INST;
                        id_pc4_q   <= '0;
                        id_valid_q <= 1'b0;
                    end else if (redirect) begin
                        // Address must stay put until the old request retires.
                        pend_pc_q  <= target;
                        id_inst_q  <= NOP_INST;
                        id_pc4_q   <= '0;
                        id_valid_q <= 1'b0;
                        state_q    <= KILL;
                    end else if (IM_Rdy && !Stall) begin
                        id_inst_q  <= IM_Data;
                        id_pc4_q   <= pc_plus4;
                        id_valid_q <= 1'b1;
                        pc_q       <= pc_plus4;
                    end else if (IM_Rdy) begin
                        buf_inst_q <= IM_Data;
                        buf_pc4_q  <= pc_plus4;
                        pc_q       <= pc_plus4;
                        state_q    <= BUF;
                    end else if (!Stall) begin
                        id_inst_q  <= NOP_INST;
                        id_pc4_q   <= '0;
                        id_valid_q <= 1'b0;
                    end
                end
                KILL: begin
                    id_inst_q  <= NOP_INST;
                    id_pc4_q   <= '0;
                    id_valid_q <= 1'b0;
                    if (IM_Rdy) begin
                        pc_q    <= pend_pc_q;
                        state_q <= FETCH;
                    end
                end
                BUF: begin
                    if (!Stall) begin
                        state_q <= FETCH;
                        if (redirect) begin
                            pc_q       <= target;
                            id_inst_q  <= NOP_INST;
                            id_pc4_q   <= '0;
                            id_valid_q <= 1'b0;
                        end else begin
                            id_inst_q  <= buf_inst_q;
                            id_pc4_q   <= buf_pc4_q;
                            id_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign IM_Req   = (state_q != BUF);
    assign IM_Addr  = pc_q;
    assign ID_Inst  = id_inst_q;
    assign ID_PC4   = id_pc4_q;
    assign ID_Valid = id_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch stream, stall, redirects, reset, wrap.
// Memory returns an address-derived word so every fetch is traceable.
module tb_if_stage;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        Jump;
    logic [25:0] ID_Target;
    logic        IM_Req;
    logic [31:0] IM_Addr;
    logic        IM_Rdy;
    logic [31:0] IM_Data;
    logic [31:0] ID_Inst;
    logic [31:0] ID_PC4;
    logic        ID_Valid;

    int n_chk  = 0;
    int n_pass = 0;

    if_stage dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Stall        (Stall),
        .Branch_Taken (Branch_Taken),
        .Branch_Target(Branch_Target),
        .Jump         (Jump),
        .ID_Target    (ID_Target),
        .IM_Req       (IM_Req),
        .IM_Addr      (IM_Addr),
        .IM_Rdy       (IM_Rdy),
        .IM_Data      (IM_Data),
        .ID_Inst      (ID_Inst),
        .ID_PC4       (ID_PC4),
        .ID_Valid     (ID_Valid)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign IM_Data = w(IM_Addr);

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic id_chk(input string tag,
                          input logic [31:0] inst,
                          input logic [31:0] pc4,
                          input logic        v);
        check({tag, ".inst"}, ID_Inst, inst);
        check({tag, ".pc4"}, ID_PC4, pc4);
        check({tag, ".valid"}, {31'd0, ID_Valid}, {31'd0, v});
    endtask

    initial begin
        Reset = 1'b1;
        Stall = 1'b0;
        Branch_Taken = 1'b0;
        Branch_Target = '0;
        Jump = 1'b0;
        ID_Target = '0;
        IM_Rdy = 1'b1;
        step();
        step();
        Reset = 1'b0;

        // Reset state
        check("rst.addr", IM_Addr, 32'h0);
        check("rst.req", {31'd0, IM_Req}, 32'd1);
        id_chk("rst", 32'h0, 32'h0, 1'b0);

        // Zero-wait stream
        step();
        check("seq0.addr", IM_Addr, 32'h4);
        id_chk("seq0", w(32'h0), 32'h4, 1'b1);
        step();
        check("seq1.addr", IM_Addr, 32'h8);
        id_chk("seq1", w(32'h4), 32'h8, 1'b1);
        step();
        id_chk("seq2", w(32'h8), 32'hC, 1'b1);
        step();
        check("seq3.addr", IM_Addr, 32'h10);
        id_chk("seq3", w(32'hC), 32'h10, 1'b1);

        // Stall three cycles with memory ready
        Stall = 1'b1;
        step();
        check("st0.req", {31'd0, IM_Req}, 32'd0);
        check("st0.addr", IM_Addr, 32'h14);
        id_chk("st0", w(32'hC), 32'h10, 1'b1);
        step();
        step();
        check("st2.req", {31'd0, IM_Req}, 32'd0);
        check("st2.addr", IM_Addr, 32'h14);
        id_chk("st2", w(32'hC), 32'h10, 1'b1);
        Stall = 1'b0;
        step();
        check("rel0.req", {31'd0, IM_Req}, 32'd1);
        check("rel0.addr", IM_Addr, 32'h14);
        id_chk("rel0", w(32'h10), 32'h14, 1'b1);
        step();
        id_chk("rel1", w(32'h14), 32'h18, 1'b1);

        // Branch to reach the upper segment for the jump case
        Branch_Taken = 1'b1;
        Branch_Target = 32'h4000_000C;
        step();
        Branch_Taken = 1'b0;
        check("br0.addr", IM_Addr, 32'h4000_000C);
        id_chk("br0", 32'h0, 32'h0, 1'b0);
        step();
        id_chk("br1", w(32'h4000_000C), 32'h4000_0010, 1'b1);

        // Jump uses upper bits of ID_PC4
        Jump = 1'b1;
        ID_Target = 26'h000_0040;
        step();
        Jump = 1'b0;
        check("j0.addr", IM_Addr, 32'h4000_0100);
        id_chk("j0", 32'h0, 32'h0, 1'b0);
        step();
        id_chk("j1", w(32'h4000_0100), 32'h4000_0104, 1'b1);

        // Branch while memory is waiting
        Branch_Taken = 1'b1;
        Branch_Target = 32'h200;
        IM_Rdy = 1'b0;
        step();
        Branch_Taken = 1'b0;
        check("k0.addr", IM_Addr, 32'h4000_0104);
        check("k0.req", {31'd0, IM_Req}, 32'd1);
        check("k0.valid", {31'd0, ID_Valid}, 32'd0);
        step();
        check("k1.addr", IM_Addr, 32'h4000_0104);
        check("k1.valid", {31'd0, ID_Valid}, 32'd0);
        step();
        check("k2.addr", IM_Addr, 32'h4000_0104);
        IM_Rdy = 1'b1;
        step();
        check("k3.addr", IM_Addr, 32'h200);
        check("k3.valid", {31'd0, ID_Valid}, 32'd0);
        step();
        id_chk("k4", w(32'h200), 32'h204, 1'b1);

        // Branch under stall is ignored; applies in BUF once released
        Branch_Taken = 1'b1;
        Branch_Target = 32'h300;
        Stall = 1'b1;
        step();
        check("bs0.addr", IM_Addr, 32'h208);
        id_chk("bs0", w(32'h200), 32'h204, 1'b1);
        Stall = 1'b0;
        step();
        Branch_Taken = 1'b0;
        check("bs1.addr", IM_Addr, 32'h300);
        check("bs1.valid", {31'd0, ID_Valid}, 32'd0);
        step();
        id_chk("bs2", w(32'h300), 32'h304, 1'b1);

        // Jump beats branch
        Jump = 1'b1;
        Branch_Taken = 1'b1;
        Branch_Target = 32'h500;
        ID_Target = 26'h000_0100;
        step();
        Jump = 1'b0;
        Branch_Taken = 1'b0;
        check("jb0.addr", IM_Addr, 32'h400);
        step();
        id_chk("jb1", w(32'h400), 32'h404, 1'b1);

        // Reset while in KILL with a response arriving
        Branch_Taken = 1'b1;
        Branch_Target = 32'h600;
        IM_Rdy = 1'b0;
        step();
        Branch_Taken = 1'b0;
        check("rk0.addr", IM_Addr, 32'h404);
        Reset = 1'b1;
        IM_Rdy = 1'b1;
        step();
        Reset = 1'b0;
        check("rk1.addr", IM_Addr, 32'h0);
        check("rk1.req", {31'd0, IM_Req}, 32'd1);
        check("rk1.valid", {31'd0, ID_Valid}, 32'd0);
        step();
        id_chk("rk2", w(32'h0), 32'h4, 1'b1);

        // PC wrap
        Branch_Taken = 1'b1;
        Branch_Target = 32'hFFFF_FFFC;
        step();
        Branch_Taken = 1'b0;
        check("wr0.addr", IM_Addr, 32'hFFFF_FFFC);
        step();
        check("wr1.addr", IM_Addr, 32'h0);
        id_chk("wr1", w(32'hFFFF_FFFC), 32'h0, 1'b1);

        // Wait state without stall gives a bubble
        IM_Rdy = 1'b0;
        step();
        check("ws.addr", IM_Addr, 32'h0);
        id_chk("ws", 32'h0, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
